axi_slv_rd_mem_bridge: RTL and testbench



---
 rtl/axi_slv_rd_mem_bridge_pkg.sv | 26 ++
 rtl/axi_slv_rd_mem_bridge_if.sv | 37 +++
 rtl/axi_slv_rd_mem_bridge_fifo.sv | 61 ++++++
 rtl/axi_slv_rd_mem_bridge.sv | 111 +++++++++++
 tb/tb_axi_slv_rd_mem_bridge.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/axi_slv_rd_mem_bridge_pkg.sv
// ============================================================================
//  Module      : axi_slv_rd_mem_bridge_pkg
//  Description : Shared widths, byte-to-word shift and reset values for the
//                AXI slave read memory bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

package axi_slv_rd_mem_bridge_pkg;
  localparam int c_AXI_ADDR_W = `AXI_ADDR_WIDTH;
  localparam int c_AXI_DATA_W = `AXI_DATA_WIDTH;
  // Number of byte-offset bits dropped from a byte address (ADDR_SHIFT).
  localparam int c_ADDR_SHIFT = $clog2(c_AXI_DATA_W / 8);

  localparam logic                    c_RST_FLAG = 1'b0;
  localparam logic [c_AXI_DATA_W-1:0] c_RST_DATA = '0;
endpackage

`default_nettype wire

// File: rtl/axi_slv_rd_mem_bridge_if.sv
// ============================================================================
//  Module      : axi_slv_rd_mem_bridge_if
//  Description : Request, result and SRAM-port signals of the read bridge.
//                slave = bridge side, master = controller/memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_slv_rd_mem_bridge_if
  import axi_slv_rd_mem_bridge_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 16
) ();
  logic                      rd_req_en;
  logic [c_AXI_ADDR_W-1:0]   rd_base_addr;
  logic                      rd_result_en;
  logic [c_AXI_DATA_W-1:0]   rd_result_data;
  logic                      mem_req;
  logic                      mem_gnt;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [c_AXI_DATA_W-1:0]   mem_rdata;
  logic                      req_full;
  logic                      busy;
  logic                      ovf_err;

  modport slave (
    input  rd_req_en, rd_base_addr, mem_gnt, mem_rdata,
    output rd_result_en, rd_result_data, mem_req, mem_addr, req_full, busy, ovf_err
  );

  modport master (
    output rd_req_en, rd_base_addr, mem_gnt, mem_rdata,
    input  rd_result_en, rd_result_data, mem_req, mem_addr, req_full, busy, ovf_err
  );
endinterface

`default_nettype wire

// File: rtl/axi_slv_rd_mem_bridge_fifo.sv
// ============================================================================
//  Module      : axi_sync_fifo
//  Description : Generic synchronous-reset FIFO; push while full is accepted
//                only together with a pop.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_push,
  input  wire logic             i_pop,
  input  wire logic [WIDTH-1:0] i_data,
  output logic      [WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic      [CNT_W-1:0] o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count   = r_count;
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; the read side is qualified by o_empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end
endmodule

`default_nettype wire

// File: rtl/axi_slv_rd_mem_bridge.sv
// ============================================================================
//  Module      : axi_slv_rd_mem_bridge
//  Description : Buffers per-beat read requests, issues them in order to a
//                fixed-latency SRAM port and returns one-cycle result pulses.
//                Optional macro: AXI_SLV_RD_MEM_BYPASS_EN (empty-FIFO bypass).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_slv_rd_mem_bridge
  import axi_slv_rd_mem_bridge_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int REQ_DEPTH      = 4,
  parameter int MEM_LAT        = 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  axi_slv_rd_mem_bridge_if.slave bus
);
  localparam int c_CNT_W = $clog2(REQ_DEPTH) + 1;

  logic [MEM_ADDR_WIDTH-1:0] w_req_addr;
  logic [MEM_ADDR_WIDTH-1:0] w_head;
  logic [MEM_ADDR_WIDTH-1:0] w_mem_addr;
  logic [c_CNT_W-1:0]        w_fifo_count;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic                      w_mem_req;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_issue;
  logic                      w_ovf;
  logic [MEM_LAT-1:0]        r_vld_sr;
  logic                      r_result_en;
  logic [c_AXI_DATA_W-1:0]   r_result_data;
  logic                      r_ovf_err;
  logic                      w_unused_addr;

  assign w_req_addr    = bus.rd_base_addr[c_ADDR_SHIFT +: MEM_ADDR_WIDTH];
  assign w_unused_addr = ^bus.rd_base_addr;

  always_comb begin
    w_mem_req  = !w_fifo_empty;
    w_mem_addr = w_fifo_empty ? '0 : w_head;
    w_push     = bus.rd_req_en;
`ifdef AXI_SLV_RD_MEM_BYPASS_EN
    // Empty FIFO: present the incoming request directly; it only enters the
    // FIFO when the arbiter does not grant it this cycle.
    if (w_fifo_empty && bus.rd_req_en) begin
      w_mem_req  = 1'b1;
      w_mem_addr = w_req_addr;
      w_push     = !bus.mem_gnt;
    end
`endif
    w_issue = w_mem_req && bus.mem_gnt;
    w_pop   = w_issue && !w_fifo_empty;
    w_ovf   = w_push && w_fifo_full && !w_pop;
  end

  axi_sync_fifo #(
    .WIDTH (MEM_ADDR_WIDTH),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_req_addr),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  generate
    if (MEM_LAT == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (!rst_n) r_vld_sr <= '0;
        else        r_vld_sr <= w_issue;
      end
    end else begin : g_latn
      always_ff @(posedge clk) begin
        if (!rst_n) r_vld_sr <= '0;
        else        r_vld_sr <= {r_vld_sr[MEM_LAT-2:0], w_issue};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result_en   <= c_RST_FLAG;
      r_result_data <= c_RST_DATA;
      r_ovf_err     <= c_RST_FLAG;
    end else begin
      r_result_en <= r_vld_sr[MEM_LAT-1];
      if (r_vld_sr[MEM_LAT-1]) r_result_data <= bus.mem_rdata;
      if (w_ovf)               r_ovf_err     <= 1'b1;
    end
  end

  assign bus.mem_req        = w_mem_req;
  assign bus.mem_addr       = w_mem_addr;
  assign bus.rd_result_en   = r_result_en;
  assign bus.rd_result_data = r_result_data;
  assign bus.req_full       = w_fifo_full;
  assign bus.busy           = (w_fifo_count != '0) || (|r_vld_sr);
  assign bus.ovf_err        = r_ovf_err;
endmodule

`default_nettype wire

// File: tb/tb_axi_slv_rd_mem_bridge.sv
// ============================================================================
//  Module      : tb_axi_slv_rd_mem_bridge
//  Description : Randomized scoreboard bench for axi_slv_rd_mem_bridge with a
//                queue-based reference model and a behavioural SRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_slv_rd_mem_bridge;
  import axi_slv_rd_mem_bridge_pkg::*;

  localparam int MAW   = 16;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;
`ifdef AXI_SLV_RD_MEM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_slv_rd_mem_bridge_if #(.MEM_ADDR_WIDTH(MAW)) bus ();

  axi_slv_rd_mem_bridge #(
    .MEM_ADDR_WIDTH (MAW),
    .REQ_DEPTH      (DEPTH),
    .MEM_LAT        (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  function automatic logic [MAW-1:0] waddr(logic [31:0] a);
    return MAW'((a / 4) % 65536);
  endfunction

  function automatic logic [31:0] mem_word(logic [MAW-1:0] w);
    return {w ^ 16'hC3A5, w};
  endfunction

  // Behavioural SRAM: returns the word LAT cycles after an issue, junk otherwise.
  logic           s_iss = 1'b0;
  logic [MAW-1:0] s_addr = '0;
  logic [LAT-1:0] p_v = '0;
  logic [MAW-1:0] p_a [LAT];
  logic [31:0]    junk = 32'hBAD0_BAD0;

  always @(negedge clk) begin
    s_iss  = bus.mem_req && bus.mem_gnt;
    s_addr = bus.mem_addr;
  end

  always @(posedge clk) begin
    p_v    <= {p_v[LAT-2:0], s_iss};
    p_a[0] <= s_addr;
    for (int i = LAT - 1; i > 0; i--) p_a[i] <= p_a[i-1];
    junk   <= $urandom;
  end

  assign bus.mem_rdata = p_v[LAT-1] ? mem_word(p_a[LAT-1]) : junk;

  // Reference model: pending word addresses, expected data, due cycles.
  logic [MAW-1:0] m_q [$];
  logic [31:0]    exp_q [$];
  int             due_q [$];
  bit             m_ovf = 1'b0;
  logic [31:0]    last_data = '0;
  int             ncyc = 0;

  function automatic void model_update(bit req, logic [31:0] addr, bit gnt);
    bit pop, byp, accept;
    if (!rst_n) begin
      m_q.delete();
      exp_q.delete();
      due_q.delete();
      m_ovf     = 1'b0;
      last_data = '0;
      return;
    end
    pop    = (m_q.size() != 0) && gnt;
    byp    = BYP && (m_q.size() == 0) && req && gnt;
    accept = req && (byp || m_q.size() < DEPTH || pop);
    if (req && !accept) m_ovf = 1'b1;
    if (accept) exp_q.push_back(mem_word(waddr(addr)));
    if (pop) begin
      void'(m_q.pop_front());
      due_q.push_back(ncyc + 1 + LAT);
    end
    if (byp)         due_q.push_back(ncyc + 1 + LAT);
    else if (accept) m_q.push_back(waddr(addr));
  endfunction

  function automatic int inflight();
    int n = 0;
    foreach (due_q[i]) if (due_q[i] > ncyc) n++;
    return n;
  endfunction

  task automatic step(bit req, logic [31:0] addr, bit gnt);
    bus.rd_req_en    = req;
    bus.rd_base_addr = addr;
    bus.mem_gnt      = gnt;
    @(posedge clk);
    model_update(req, addr, gnt);
    #1;
  endtask

  // Monitor: compares every presented result and the visible status.
  always @(negedge clk) begin
    logic [31:0] e;
    bit          exp_req;
    ncyc++;
    if (rst_n) begin
      if (bus.rd_result_en) begin
        if (exp_q.size() == 0 || due_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_result: got rd_result_en=1 data=0x%0h at cycle %0d, required no result",
                   bus.rd_result_data, ncyc);
        end else begin
          e = exp_q.pop_front();
          chk("result_data", bus.rd_result_data, e);
          chk("result_cycle", ncyc, due_q.pop_front());
          last_data = e;
        end
      end else begin
        chk("result_hold", bus.rd_result_data, last_data);
      end
      exp_req = (m_q.size() != 0) || (BYP && bus.rd_req_en);
      chk("mem_req", bus.mem_req, exp_req);
      if (exp_req)
        chk("mem_addr", bus.mem_addr, (m_q.size() != 0) ? m_q[0] : waddr(bus.rd_base_addr));
      chk("req_full", bus.req_full, m_q.size() == DEPTH);
      chk("ovf_err", bus.ovf_err, m_ovf);
      chk("busy", bus.busy, (m_q.size() != 0) || (inflight() != 0));
    end
  end

  task automatic do_reset(int n);
    rst_n = 1'b0;
    repeat (n) step(1'b0, 32'h0, 1'b0);
    chk("rst_result_en", bus.rd_result_en, 0);
    chk("rst_result_data", bus.rd_result_data, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_req_full", bus.req_full, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ovf_err", bus.ovf_err, 0);
    rst_n = 1'b1;
  endtask

  task automatic idle(int n, bit gnt);
    repeat (n) step(1'b0, 32'h0, gnt);
  endtask

  initial begin
    bus.rd_req_en    = 1'b0;
    bus.rd_base_addr = '0;
    bus.mem_gnt      = 1'b0;
    do_reset(3);
    idle(2, 1'b1);

    // Single request at byte address 0x40.
`ifdef AXI_SLV_RD_MEM_BYPASS_EN
    bus.rd_req_en = 1'b1; bus.rd_base_addr = 32'h40; bus.mem_gnt = 1'b1;
    #1;
    chk("byp_mem_req", bus.mem_req, 1);
    chk("byp_mem_addr", bus.mem_addr, 16'h10);
    @(posedge clk);
    model_update(1'b1, 32'h40, 1'b1);
    #1;
`else
    step(1'b1, 32'h40, 1'b1);
    chk("single_mem_req", bus.mem_req, 1);
    chk("single_mem_addr", bus.mem_addr, 16'h10);
`endif
    idle(8, 1'b1);

    // Eight back-to-back requests, grant held.
    for (int i = 0; i < 8; i++) step(1'b1, 32'(i * 4), 1'b1);
    idle(8, 1'b1);

    // Four requests with grant withheld: FIFO fills without dropping.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(i * 4), 1'b0);
    chk("hold_full", bus.req_full, 1);
    chk("hold_no_ovf", bus.ovf_err, 0);
    idle(10, 1'b1);

    // Five requests with grant withheld: the fifth overflows.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h200 + 32'(i * 4), 1'b0);
    chk("ovf_set", bus.ovf_err, 1);
    idle(10, 1'b1);
    chk("ovf_sticky", bus.ovf_err, 1);
    do_reset(1);
    idle(2, 1'b1);

    // Reset with two reads in flight: nothing may come back afterwards.
    step(1'b1, 32'h300, 1'b1);
    step(1'b1, 32'h304, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    do_reset(1);
    idle(8, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 65);

    // Bounded drain.
    for (int i = 0; i < 60 && (exp_q.size() != 0 || m_q.size() != 0); i++) idle(1, 1'b1);
    idle(2, 1'b1);
    chk("drain_empty", exp_q.size(), 0);
    chk("idle_busy", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

`default_nettype wire
